// File: rtl/rb_ctrl_pkg.sv
// Shared types and width helpers for the row-buffer controller.
package rb_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } rb_state_e;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

   function automatic int unsigned col_width(input int unsigned image_width);
      return cnt_width(image_width);
   endfunction

   function automatic int unsigned row_width(input int unsigned image_height);
      return cnt_width(image_height);
   endfunction

   function automatic int unsigned sel_width(input int unsigned rb_count);
      return cnt_width(rb_count);
   endfunction

endpackage

// File: rtl/row_buffer_ctrl_wrap_counter.sv
// Modulo counter: counts on i_en, returns to zero after i_max. o_wrap flags the
// terminal value so the owner can chain the next counter off (i_en & o_wrap).
module wrap_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_max,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_wrap
);

   logic [WIDTH-1:0] r_cnt;

   assign o_wrap = (r_cnt == i_max);
   assign o_cnt  = r_cnt;

   // count register: clear wins over enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {WIDTH{1'b0}};
      end else if (i_clr) begin
         r_cnt <= {WIDTH{1'b0}};
      end else if (i_en) begin
         r_cnt <= o_wrap ? {WIDTH{1'b0}} : r_cnt + WIDTH'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/row_buffer_ctrl.sv
// Row-buffer controller: steers an incoming pixel stream round-robin into
// RB_COUNT line buffers and issues column reads once RB_COUNT-1 rows are held.
module row_buffer_ctrl
   import rb_ctrl_pkg::*;
#(
   parameter int unsigned RB_COUNT     = 8,
   parameter int unsigned IMAGE_WIDTH  = 256,
   parameter int unsigned IMAGE_HEIGHT = 256
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [RB_COUNT-1:0]            wr_en,
   output logic [$clog2(IMAGE_WIDTH)-1:0] wr_addr,
   output logic                           rd_en,
   output logic [$clog2(IMAGE_WIDTH)-1:0] rd_addr,
   output logic [$clog2(RB_COUNT)-1:0]    rb_base,
   output logic                           window_valid,
   output logic                           busy,
   output logic                           frame_done
);

   localparam int unsigned CW = col_width(IMAGE_WIDTH);
   localparam int unsigned RW = row_width(IMAGE_HEIGHT);
   localparam int unsigned SW = sel_width(RB_COUNT);

   localparam logic [CW-1:0] COL_MAX       = CW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX       = RW'(IMAGE_HEIGHT - 1);
   localparam logic [SW-1:0] SEL_MAX       = SW'(RB_COUNT - 1);
   localparam logic [RW-1:0] FILL_LAST_ROW = RW'(RB_COUNT - 2);

   rb_state_e r_state;
   rb_state_e w_state_nxt;

   logic                w_accept;
   logic                w_clr;
   logic                w_row_step;
   logic                w_col_last;
   logic                w_row_last;
   logic                w_sel_last;
   logic [CW-1:0]       w_col;
   logic [RW-1:0]       w_row;
   logic [SW-1:0]       w_sel;
   logic [RB_COUNT-1:0] w_sel_onehot;

   logic [RB_COUNT-1:0] r_wr_en;
   logic [CW-1:0]       r_wr_addr;
   logic                r_rd_en;
   logic [CW-1:0]       r_rd_addr;
   logic [SW-1:0]       r_rb_base;
   logic                r_window_valid;

   assign w_clr        = (r_state == ST_IDLE) & start;
   assign w_accept     = in_valid & in_ready;
   assign w_row_step   = w_accept & w_col_last;
   assign w_sel_onehot = {{(RB_COUNT-1){1'b0}}, 1'b1} << w_sel;

   wrap_counter #(.WIDTH(CW)) u_col (
      .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_en(w_accept),
      .i_max(COL_MAX), .o_cnt(w_col), .o_wrap(w_col_last)
   );

   wrap_counter #(.WIDTH(RW)) u_row (
      .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_en(w_row_step),
      .i_max(ROW_MAX), .o_cnt(w_row), .o_wrap(w_row_last)
   );

   wrap_counter #(.WIDTH(SW)) u_sel (
      .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_en(w_row_step),
      .i_max(SEL_MAX), .o_cnt(w_sel), .o_wrap(w_sel_last)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state; start is only honoured from IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_FILL; else w_state_nxt = ST_IDLE;
         ST_FILL: if (w_row_step && (w_row == FILL_LAST_ROW)) w_state_nxt = ST_RUN;
                  else w_state_nxt = ST_FILL;
         ST_RUN:  if (w_row_step && w_row_last) w_state_nxt = ST_DONE;
                  else w_state_nxt = ST_RUN;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state-decoded outputs
   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (r_state)
         ST_FILL: begin in_ready = 1'b1; busy = 1'b1; end
         ST_RUN:  begin in_ready = 1'b1; busy = 1'b1; end
         ST_DONE: frame_done = 1'b1;
         default: frame_done = 1'b0;
      endcase
   end

   // write/read strobes one cycle after accept; window_valid trails the BRAM read by one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en        <= {RB_COUNT{1'b0}};
         r_wr_addr      <= {CW{1'b0}};
         r_rd_en        <= 1'b0;
         r_rd_addr      <= {CW{1'b0}};
         r_rb_base      <= {SW{1'b0}};
         r_window_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_en   <= w_sel_onehot;
            r_wr_addr <= w_col;
         end else begin
            r_wr_en   <= {RB_COUNT{1'b0}};
         end
         // the buffer after the one being written holds the oldest row
         if (w_accept && (r_state == ST_RUN)) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= w_col;
            r_rb_base <= w_sel_last ? {SW{1'b0}} : w_sel + SW'(1);
         end else begin
            r_rd_en   <= 1'b0;
         end
         r_window_valid <= r_rd_en;
      end
   end

   assign wr_en        = r_wr_en;
   assign wr_addr      = r_wr_addr;
   assign rd_en        = r_rd_en;
   assign rd_addr      = r_rd_addr;
   assign rb_base      = r_rb_base;
   assign window_valid = r_window_valid;

endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Self-checking bench for row_buffer_ctrl (RB_COUNT=4, IMAGE_WIDTH=8, IMAGE_HEIGHT=6).
module tb_row_buffer_ctrl;

   localparam int RB   = 4;
   localparam int W    = 8;
   localparam int H    = 6;
   localparam int CW   = 3;
   localparam int SW   = 2;
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [RB-1:0] wr_en;
   logic [CW-1:0] wr_addr;
   logic          rd_en;
   logic [CW-1:0] rd_addr;
   logic [SW-1:0] rb_base;
   logic          window_valid;
   logic          busy;
   logic          frame_done;

   always #5 clk = ~clk;

   row_buffer_ctrl #(.RB_COUNT(RB), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en),
      .rd_addr(rd_addr), .rb_base(rb_base), .window_valid(window_valid),
      .busy(busy), .frame_done(frame_done)
   );

   // Model: pixel k of a frame sits at row k/W, column k%W, in buffer (k/W)%RB.
   bit            m_active;
   int            m_cnt;
   logic          e_done;
   logic [RB-1:0] e_wr_en;
   logic [CW-1:0] e_wr_addr;
   logic          e_rd_en;
   logic [CW-1:0] e_rd_addr;
   logic [SW-1:0] e_rb_base;
   logic          e_wv;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active  <= 1'b0;
         m_cnt     <= 0;
         e_done    <= 1'b0;
         e_wr_en   <= '0;
         e_wr_addr <= '0;
         e_rd_en   <= 1'b0;
         e_rd_addr <= '0;
         e_rb_base <= '0;
         e_wv      <= 1'b0;
      end else begin
         e_wv   <= e_rd_en;
         e_done <= m_active && in_valid && (m_cnt == NPIX - 1);
         if (m_active && in_valid) begin
            e_wr_en   <= RB'(1) << ((m_cnt / W) % RB);
            e_wr_addr <= CW'(m_cnt % W);
            e_rd_en   <= ((m_cnt / W) >= RB - 1);
            if ((m_cnt / W) >= RB - 1) begin
               e_rd_addr <= CW'(m_cnt % W);
               e_rb_base <= SW'(((m_cnt / W) + 1) % RB);
            end
            m_cnt <= m_cnt + 1;
            if (m_cnt == NPIX - 1) m_active <= 1'b0;
         end else begin
            e_wr_en <= '0;
            e_rd_en <= 1'b0;
            if (!m_active && !e_done && start) begin
               m_active <= 1'b1;
               m_cnt    <= 0;
            end
         end
      end
   end

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int busy_cnt, rd_cnt, wv_cnt, done_cnt, done_base, acc_n;
   int acc25_cyc, rd_first_cyc, done_cyc, stream_start;
   int wr_cnt [RB];
   logic [CW-1:0] rd_first_addr;
   logic [SW-1:0] rd_first_base;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic monitor();
      chk("in_ready", in_ready, m_active);
      chk("busy", busy, m_active);
      chk("wr_en", wr_en, e_wr_en);
      chk("wr_addr", wr_addr, e_wr_addr);
      chk("rd_en", rd_en, e_rd_en);
      chk("rd_addr", rd_addr, e_rd_addr);
      chk("rb_base", rb_base, e_rb_base);
      chk("window_valid", window_valid, e_wv);
      chk("frame_done", frame_done, e_done);
      if (busy) busy_cnt++;
      for (int b = 0; b < RB; b++) if (wr_en[b]) wr_cnt[b]++;
      if (rd_en) begin
         rd_cnt++;
         if (rd_first_cyc < 0) begin
            rd_first_cyc  = cyc;
            rd_first_addr = rd_addr;
            rd_first_base = rb_base;
         end
      end
      if (window_valid) wv_cnt++;
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (m_active && in_valid) begin
         acc_n++;
         if (acc_n == 25) acc25_cyc = cyc;
      end
   endtask

   // one clock: check mid-cycle, then return just after the next rising edge
   task automatic tick();
      @(negedge clk);
      if (rst_n) monitor();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      busy_cnt = 0; rd_cnt = 0; wv_cnt = 0; acc_n = 0;
      acc25_cyc = -1; rd_first_cyc = -1; done_cyc = -1;
      done_base = done_cnt;
      for (int b = 0; b < RB; b++) wr_cnt[b] = 0;
   endtask

   task automatic begin_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      stream_start = cyc;
   endtask

   task automatic wait_cnt(input int n);
      for (int i = 0; i < 200 && m_cnt != n; i++) tick();
      chk("accept_count_reached", m_cnt, n);
   endtask

   task automatic wait_done(input int bound);
      for (int i = 0; i < bound && done_cnt == done_base; i++) tick();
   endtask

   // full-frame expectations; rows go to buffers 0,1,2,3,0,1
   task automatic frame_check(input string tag, input int busy_exp, input int lat_exp);
      chk({tag, "_busy_cycles"}, busy_cnt, busy_exp);
      chk({tag, "_wr_buf0"}, wr_cnt[0], 16);
      chk({tag, "_wr_buf1"}, wr_cnt[1], 16);
      chk({tag, "_wr_buf2"}, wr_cnt[2], 8);
      chk({tag, "_wr_buf3"}, wr_cnt[3], 8);
      chk({tag, "_rd_count"}, rd_cnt, 24);
      chk({tag, "_wv_count"}, wv_cnt, 24);
      chk({tag, "_done_count"}, done_cnt - done_base, 1);
      chk({tag, "_done_latency"}, done_cyc - stream_start, lat_exp);
      chk({tag, "_first_rd_delay"}, rd_first_cyc - acc25_cyc, 1);
      chk({tag, "_first_rd_addr"}, rd_first_addr, 0);
      chk({tag, "_first_rb_base"}, rd_first_base, 0);
      chk({tag, "_model_accepts"}, m_cnt, NPIX);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      done_cnt = 0;
      clr_stats();
      repeat (3) tick();
      chk("reset_outputs", {in_ready, busy, wr_en, wr_addr, rd_en, rd_addr,
                            rb_base, window_valid, frame_done}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // continuous stream: 48 accepts, frame_done in cycle 48 of the frame
      clr_stats();
      in_valid = 1'b1;
      begin_frame();
      wait_done(200);
      in_valid = 1'b0;
      repeat (4) tick();
      frame_check("cont", 48, 48);

      // in_valid 1/0 alternating: accepts on even cycles 0..94, done on cycle 95
      clr_stats();
      begin_frame();
      in_valid = 1'b1;
      for (int i = 0; i < 300 && done_cnt == done_base; i++) begin
         tick();
         in_valid = ~in_valid;
      end
      in_valid = 1'b0;
      repeat (4) tick();
      frame_check("toggle", 95, 95);

      // reset after accept #30 discards the frame
      clr_stats();
      in_valid = 1'b1;
      begin_frame();
      wait_cnt(30);
      chk("rst_accepts_before", acc_n, 30);
      #1 rst_n = 1'b0;
      #1;
      chk("midframe_reset_outputs", {in_ready, busy, wr_en, wr_addr, rd_en, rd_addr,
                                     rb_base, window_valid, frame_done}, 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("rst_no_frame_done", done_cnt - done_base, 0);
      clr_stats();
      begin_frame();
      wait_done(200);
      in_valid = 1'b0;
      repeat (4) tick();
      frame_check("restart", 48, 48);

      // start pulses in RUN and across the last accept + DONE are ignored
      clr_stats();
      in_valid = 1'b1;
      begin_frame();
      wait_cnt(30);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_cnt(47);
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      repeat (6) tick();
      frame_check("start_ignored", 48, 48);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
